// File: rtl/bus_arbiter.sv
// Shares the SRAM/ROM bus between the 6502 CPU (phi_0 high) and one FDC DMA access per phi_0-low phase.
// Define BUS_ARB_STATS_EN to add the DMA transfer counter and the sticky phase-overlap flag.
module bus_arbiter #(
   parameter int         SRAM_AW       = 13,
   parameter logic [7:0] UNMAPPED_DATA = 8'hFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               phi_0,
   input  logic [15:0]        cpu_addr,
   input  logic               cpu_rw,
   input  logic [7:0]         cpu_wdata,
   output logic [7:0]         cpu_rdata,
   input  logic               dma_req,
   input  logic               dma_we,
   input  logic [SRAM_AW-1:0] dma_addr,
   input  logic [7:0]         dma_wdata,
   output logic               dma_ack,
   output logic [7:0]         dma_rdata,
   output logic [15:0]        mem_addr,
   output logic [7:0]         mem_wdata,
   input  logic [7:0]         mem_rdata,
   output logic               sram_en,
   output logic               sram_we,
   output logic               rom_oe,
   output logic [15:0]        dma_count,
   output logic               conflict
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CPU      = 2'd1;
   localparam logic [1:0] ST_DMA_ADDR = 2'd2;
   localparam logic [1:0] ST_DMA_DATA = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [SRAM_AW-1:0] dma_addr_q;
   logic               dma_we_q;
   logic [7:0]         dma_wdata_q;
   logic [7:0]         cpu_rdata_q, cpu_rdata_d;
   logic [7:0]         dma_rdata_q, dma_rdata_d;
   logic               dma_done_q, dma_done_d;
   logic               take_dma;
   logic               cpu_sram;
   logic               cpu_mapped;
   logic [15:0]        dma_addr_ext;

   assign cpu_sram     = (cpu_addr[15:SRAM_AW] == '0);
   assign cpu_mapped   = cpu_sram | cpu_addr[15];
   assign dma_addr_ext = {{(16-SRAM_AW){1'b0}}, dma_addr_q};

   // dma_done blocks a second transfer in the same low phase until the CPU has owned the bus again
   always_comb begin
      state_d     = state_q;
      take_dma    = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      dma_done_d  = dma_done_q;
      case (state_q)
         ST_IDLE: begin
            if (phi_0) begin
               state_d = ST_CPU;
            end else if (dma_req && !dma_done_q) begin
               state_d  = ST_DMA_ADDR;
               take_dma = 1'b1;
            end
         end
         ST_CPU: begin
            dma_done_d = 1'b0;
            if (!phi_0) begin
               if (cpu_rw) begin
                  cpu_rdata_d = cpu_mapped ? mem_rdata : UNMAPPED_DATA;
               end
               if (dma_req) begin
                  state_d  = ST_DMA_ADDR;
                  take_dma = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DMA_ADDR: begin
            state_d = ST_DMA_DATA;
         end
         ST_DMA_DATA: begin
            dma_done_d = 1'b1;
            if (!dma_we_q) begin
               dma_rdata_d = mem_rdata;
            end
            state_d = phi_0 ? ST_CPU : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         dma_addr_q  <= '0;
         dma_we_q    <= 1'b0;
         dma_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         dma_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         dma_done_q  <= dma_done_d;
         if (take_dma) begin
            dma_addr_q  <= dma_addr;
            dma_we_q    <= dma_we;
            dma_wdata_q <= dma_wdata;
         end
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      sram_en   = 1'b0;
      sram_we   = 1'b0;
      rom_oe    = 1'b0;
      case (state_q)
         ST_CPU: begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            sram_en   = cpu_sram;
            rom_oe    = cpu_rw & cpu_addr[15];
            sram_we   = cpu_sram & ~cpu_rw & phi_0;
         end
         ST_DMA_ADDR: begin
            mem_addr  = dma_addr_ext;
            mem_wdata = dma_wdata_q;
            sram_en   = 1'b1;
            sram_we   = dma_we_q;
         end
         ST_DMA_DATA: begin
            mem_addr  = dma_addr_ext;
            mem_wdata = dma_wdata_q;
         end
         default: ;
      endcase
   end

   assign dma_ack   = (state_q == ST_DMA_DATA);
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;

`ifdef BUS_ARB_STATS_EN
   logic [15:0] dma_count_q;
   logic        conflict_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dma_count_q <= '0;
         conflict_q  <= 1'b0;
      end else begin
         if (state_q == ST_DMA_DATA) begin
            dma_count_q <= dma_count_q + 16'd1;
         end
         if (phi_0 && (state_q == ST_DMA_ADDR || state_q == ST_DMA_DATA)) begin
            conflict_q <= 1'b1;
         end
      end
   end

   assign dma_count = dma_count_q;
   assign conflict  = conflict_q;
`else
   assign dma_count = '0;
   assign conflict  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus a randomized run checked every cycle against a bus-ownership model.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst, phi_0;
   logic [15:0] cpu_addr;
   logic        cpu_rw;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        dma_req, dma_we, dma_ack;
   logic [12:0] dma_addr;
   logic [7:0]  dma_wdata, dma_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        sram_en, sram_we, rom_oe, conflict;
   logic [15:0] dma_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bus_arbiter dut (
      .clk(clk), .rst(rst), .phi_0(phi_0),
      .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .sram_en(sram_en), .sram_we(sram_we), .rom_oe(rom_oe),
      .dma_count(dma_count), .conflict(conflict)
   );

   function automatic logic [7:0] rom_byte(input logic [15:0] a);
      return 8'h4C ^ a[7:0] ^ {1'b0, a[14:8]};
   endfunction

   // memory array: registered read, garbage when nothing is enabled
   logic [7:0] dev_mem [0:8191];
   always @(posedge clk) begin
      if (sram_en && sram_we) dev_mem[mem_addr[12:0]] <= mem_wdata;
      if (sram_en)     mem_rdata <= dev_mem[mem_addr[12:0]];
      else if (rom_oe) mem_rdata <= rom_byte(mem_addr);
      else             mem_rdata <= 8'($urandom);
   end

   // bus-ownership model: who holds the bus, how far along the DMA access is, transaction-level memory
   bit          m_cpu;
   int          m_dma_left;
   bit          m_spent;
   logic [12:0] m_a;
   bit          m_we;
   logic [7:0]  m_d;
   logic [7:0]  m_cpu_rdata, m_dma_rdata;
   logic [15:0] m_count;
   bit          m_conflict;
   logic [7:0]  ref_mem [0:8191];

   bit rand_mode = 0;
   bit hold_req  = 0;
   int pend      = 0;
   int ph_left   = 0;
   int ack_seen  = 0;

   task automatic model_reset();
      m_cpu = 0; m_dma_left = 0; m_spent = 0;
      m_cpu_rdata = 8'h00; m_dma_rdata = 8'h00; m_count = 16'h0; m_conflict = 0;
   endtask

   task automatic model_start();
      m_dma_left = 2; m_a = dma_addr; m_we = dma_we; m_d = dma_wdata;
   endtask

   task automatic model_step();
      if (rst) begin
         model_reset();
      end else if (m_dma_left == 2) begin
         if (phi_0) m_conflict = 1;
         if (m_we) ref_mem[m_a] = m_d;
         m_dma_left = 1;
      end else if (m_dma_left == 1) begin
         if (phi_0) m_conflict = 1;
         if (!m_we) m_dma_rdata = ref_mem[m_a];
         m_count++;
         m_spent = 1;
         m_dma_left = 0;
         m_cpu = phi_0;
      end else if (m_cpu) begin
         m_spent = 0;
         if (phi_0) begin
            if (!cpu_rw && cpu_addr < 16'h2000) ref_mem[cpu_addr[12:0]] = cpu_wdata;
         end else begin
            if (cpu_rw) begin
               if (cpu_addr < 16'h2000)       m_cpu_rdata = ref_mem[cpu_addr[12:0]];
               else if (cpu_addr >= 16'h8000) m_cpu_rdata = rom_byte(cpu_addr);
               else                           m_cpu_rdata = 8'hFF;
            end
            m_cpu = 0;
            if (dma_req) model_start();
         end
      end else begin
         if (phi_0) m_cpu = 1;
         else if (dma_req && !m_spent) model_start();
      end
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic e_en, e_we, e_oe, e_ack;
      logic [15:0] e_addr, e_cnt;
      logic [7:0] e_wd;
      logic e_conf;
      e_en = 0; e_we = 0; e_oe = 0; e_ack = 0; e_addr = 16'h0; e_wd = 8'h0;
      if (m_dma_left == 2) begin
         e_en = 1; e_we = m_we; e_addr = {3'b000, m_a}; e_wd = m_d;
      end else if (m_dma_left == 1) begin
         e_ack = 1;
      end else if (m_cpu) begin
         e_en   = (cpu_addr < 16'h2000);
         e_oe   = cpu_rw && (cpu_addr >= 16'h8000);
         e_we   = e_en && !cpu_rw && phi_0;
         e_addr = cpu_addr;
         e_wd   = cpu_wdata;
      end
`ifdef BUS_ARB_STATS_EN
      e_cnt = m_count; e_conf = m_conflict;
`else
      e_cnt = 16'h0; e_conf = 0;
`endif
      chk("sram_en", 16'(sram_en), 16'(e_en));
      chk("sram_we", 16'(sram_we), 16'(e_we));
      chk("rom_oe", 16'(rom_oe), 16'(e_oe));
      chk("dma_ack", 16'(dma_ack), 16'(e_ack));
      if (e_en || e_oe) chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", 16'(mem_wdata), 16'(e_wd));
      chk("cpu_rdata", 16'(cpu_rdata), 16'(m_cpu_rdata));
      chk("dma_rdata", 16'(dma_rdata), 16'(m_dma_rdata));
      chk("dma_count", dma_count, e_cnt);
      chk("conflict", 16'(conflict), 16'(e_conf));
   endtask

   task automatic requester();
      if (dma_req) begin
         if (dma_ack) begin
            total++;
            pend = 0;
            if (!hold_req) dma_req = 0;
         end else begin
            pend++;
            if (pend > 60) begin
               total++; bad++;
               $display("FAIL dma_timeout: got no ack after %0d cycles expected ack", pend);
               dma_req = 0; pend = 0;
            end
         end
      end
      if (rand_mode && !dma_req && $urandom_range(0, 3) == 0) begin
         dma_req   = 1;
         dma_we    = 1'($urandom);
         dma_addr  = 13'($urandom_range(0, 15)) | (($urandom % 2) ? 13'h1FF0 : 13'h0);
         dma_wdata = 8'($urandom);
      end
   endtask

   task automatic random_phase();
      ph_left--;
      if (ph_left <= 0) begin
         phi_0 = ~phi_0;
         if (phi_0) begin
            ph_left = $urandom_range(3, 5);
            cpu_rw    = 1'($urandom);
            cpu_wdata = 8'($urandom);
            case ($urandom_range(0, 3))
               0, 1:    cpu_addr = 16'($urandom_range(0, 15)) | (($urandom % 2) ? 16'h1FF0 : 16'h0);
               2:       cpu_addr = 16'h8000 | 16'($urandom);
               default: cpu_addr = 16'($urandom_range(16'h2000, 16'h7FFF));
            endcase
         end else begin
            ph_left = $urandom_range(1, 4);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      model_step();
      if (dma_ack) ack_seen++;
      requester();
      if (rand_mode) random_phase();
      #1;
      check_outputs();
   endtask

   task automatic phase(input int h, input int l);
      phi_0 = 1;
      repeat (h) adv();
      phi_0 = 0;
      repeat (l) adv();
   endtask

   initial begin
      logic [7:0] v;
      for (int i = 0; i < 8192; i++) begin
         v = 8'($urandom);
         dev_mem[i] <= v;
         ref_mem[i] = v;
      end
      rst = 1; phi_0 = 0; cpu_addr = 16'h0; cpu_rw = 1; cpu_wdata = 8'h0;
      dma_req = 0; dma_we = 0; dma_addr = 13'h0; dma_wdata = 8'h0;
      model_reset();

      // reset while phi_0 toggles
      for (int i = 0; i < 6; i++) begin
         adv();
         phi_0 = ~phi_0;
      end
      chk("rst_cpu_rdata", 16'(cpu_rdata), 16'h0);
      chk("rst_mem_addr", mem_addr, 16'h0);
      phi_0 = 0; rst = 0;
      adv();

      // ROM read at $8000
      cpu_addr = 16'h8000; cpu_rw = 1; phi_0 = 1;
      adv();
      chk("rom_oe_cpu", 16'(rom_oe), 16'h1);
      chk("rom_sram_en", 16'(sram_en), 16'h0);
      adv(); adv();
      phi_0 = 0;
      adv();
      chk("rom_read", 16'(cpu_rdata), 16'h4C);
      adv(); adv();

      // CPU write AA to $0000, strobe only while phi_0 is high
      cpu_addr = 16'h0000; cpu_rw = 0; cpu_wdata = 8'hAA; phi_0 = 1;
      adv();
      chk("cpu_we_high", 16'(sram_we), 16'h1);
      adv(); adv();
      phi_0 = 0;
      #1;
      chk("cpu_we_low", 16'(sram_we), 16'h0);
      adv(); adv(); adv();
      cpu_rw = 1;
      phase(3, 3);
      chk("sram_readback", 16'(cpu_rdata), 16'hAA);
      cpu_addr = 16'h4000;
      phase(3, 3);
      chk("unmapped_read", 16'(cpu_rdata), 16'hFF);

      // DMA write 55 to $1FFF held through a CPU phase
      cpu_addr = 16'h0010; dma_req = 1; dma_we = 1; dma_addr = 13'h1FFF; dma_wdata = 8'h55;
      phi_0 = 1;
      repeat (3) adv();
      phi_0 = 0;
      adv();
      chk("dma_wr_addr", mem_addr, 16'h1FFF);
      chk("dma_wr_we", 16'(sram_we), 16'h1);
      chk("dma_wr_noack", 16'(dma_ack), 16'h0);
      adv();
      chk("dma_wr_ack", 16'(dma_ack), 16'h1);
      adv();
      chk("dma_ack_single", 16'(dma_ack), 16'h0);
      dma_req = 1; dma_we = 0; dma_addr = 13'h1FFF;
      phase(3, 3);
      chk("dma_readback", 16'(dma_rdata), 16'h55);

      // request held across three periods: one transfer per low phase
      hold_req = 1; dma_req = 1; dma_we = 0; dma_addr = 13'h0003; ack_seen = 0;
      repeat (3) phase(3, 3);
      hold_req = 0; dma_req = 0; pend = 0;
      chk("three_acks", 16'(ack_seen), 16'd3);
`ifdef BUS_ARB_STATS_EN
      chk("count_five", dma_count, 16'd5);
`else
      chk("count_zero", dma_count, 16'd0);
`endif

      // one-cycle low phase: transfer completes, CPU entry delayed
      cpu_addr = 16'h8000; cpu_rw = 1; dma_req = 1; dma_we = 0; dma_addr = 13'h0007;
      phi_0 = 1;
      repeat (3) adv();
      phi_0 = 0;
      adv();
      phi_0 = 1;
      adv();
      chk("conf_ack", 16'(dma_ack), 16'h1);
      adv();
      chk("conf_cpu_rom", 16'(rom_oe), 16'h1);
`ifdef BUS_ARB_STATS_EN
      chk("conf_flag", 16'(conflict), 16'h1);
`else
      chk("conf_flag", 16'(conflict), 16'h0);
`endif
      adv(); adv();
      phi_0 = 0;
      repeat (3) adv();

      // reset in DMA_ADDR aborts the transfer
      dma_req = 1; dma_we = 0; dma_addr = 13'h0009;
      phi_0 = 1;
      repeat (3) adv();
      phi_0 = 0;
      adv();
      chk("abort_in_addr", 16'(sram_en), 16'h1);
      rst = 1; ack_seen = 0;
      #1;
      chk("abort_en", 16'(sram_en), 16'h0);
      chk("abort_we", 16'(sram_we), 16'h0);
      chk("abort_ack", 16'(dma_ack), 16'h0);
      model_reset();
      dma_req = 0; pend = 0;
      adv(); adv();
      rst = 0;
      repeat (5) adv();
      chk("abort_noack", 16'(ack_seen), 16'd0);
      chk("abort_count", dma_count, 16'd0);

      // randomized traffic
      rand_mode = 1; ph_left = 1;
      repeat (3000) adv();
      rand_mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
